// File: rtl/venus_ex_pkg.sv
// venus_ex_pkg: condition codes, flag bit positions and the EX output entry layout.
package venus_ex_pkg;
  localparam logic [3:0] COND_AL = 4'd0;
  localparam logic [3:0] COND_EQ = 4'd1;
  localparam logic [3:0] COND_NE = 4'd2;
  localparam logic [3:0] COND_GT = 4'd3;
  localparam logic [3:0] COND_LT = 4'd4;
  localparam logic [3:0] COND_VS = 4'd5;
  localparam logic [3:0] COND_VC = 4'd6;
  localparam logic [3:0] COND_HI = 4'd7;
  localparam logic [3:0] COND_LE = 4'd8;
  localparam logic [3:0] COND_NV = 4'd9;
  localparam int FLAG_Z = 0;
  localparam int FLAG_P = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int EX_DATA_W = 32;
  localparam int EX_RD_W = 5;
  // Entry layout at default widths; ex_out_stage keeps the same field order at its own widths.
  typedef struct packed {
    logic [EX_DATA_W-1:0] result;
    logic [EX_RD_W-1:0]   rd;
    logic                 rd_we;
    logic                 branch_taken;
  } ex_entry_t;
endpackage

// File: rtl/ex_cond_eval.sv
// ex_cond_eval: evaluates a 4-bit condition code against {V,N,P,Z} flags.
module ex_cond_eval
  import venus_ex_pkg::*;
(
  input  logic [3:0] flags_i,
  input  logic [3:0] cond_i,
  output logic       taken_o
);
  logic w_z, w_p, w_n, w_v;
  assign w_z = flags_i[FLAG_Z];
  assign w_p = flags_i[FLAG_P];
  assign w_n = flags_i[FLAG_N];
  assign w_v = flags_i[FLAG_V];
  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_AL: taken_o = 1'b1;
      COND_EQ: taken_o = w_z;
      COND_NE: taken_o = ~w_z;
      COND_GT: taken_o = w_p;
      COND_LT: taken_o = w_n;
      COND_VS: taken_o = w_v;
      COND_VC: taken_o = ~w_v;
      COND_HI: taken_o = w_p & ~w_z;
      COND_LE: taken_o = w_n | w_z;
      default: taken_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/ex_out_stage.sv
// ex_out_stage: two-entry skid buffer on the EX result path, owning the flag register
// and resolving conditional branches at accept time.
module ex_out_stage
  import venus_ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] result_i,
  input  logic              zero_flag_i,
  input  logic              pos_flag_i,
  input  logic              neg_flag_i,
  input  logic              overflow_flag_i,
  input  logic              flag_we_i,
  input  logic              branch_i,
  input  logic [3:0]        cond_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic              rd_we_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic [RD_W-1:0]   rd_o,
  output logic              rd_we_o,
  output logic              branch_taken_o,
  output logic [3:0]        flags_o
);
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic              rd_we;
    logic              branch_taken;
  } entry_t;
  entry_t     r_main, r_skid, w_entry;
  logic       r_main_v, r_skid_v;
  logic [3:0] r_flags;
  logic       w_accept, w_xfer, w_taken;
  logic [3:0] w_in_flags, w_cond_flags;
  assign ready_o      = ~r_skid_v;
  assign w_accept     = valid_i & ready_o & ~flush_i;
  assign w_xfer       = r_main_v & ready_i;
  assign w_in_flags   = {overflow_flag_i, neg_flag_i, pos_flag_i, zero_flag_i};
  // Compare-and-branch sees the flags it is about to write, not the stale register.
  assign w_cond_flags = flag_we_i ? w_in_flags : r_flags;
  ex_cond_eval u_cond (
    .flags_i(w_cond_flags),
    .cond_i (cond_i),
    .taken_o(w_taken)
  );
  assign w_entry = '{result: result_i, rd: rd_i, rd_we: rd_we_i, branch_taken: branch_i & w_taken};
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main   <= '0;
      r_skid   <= '0;
      r_flags  <= '0;
    end else begin
      if (w_accept && flag_we_i) r_flags <= w_in_flags;
      if (flush_i) begin
        r_main_v <= 1'b0;
        r_skid_v <= 1'b0;
      end else if (!r_main_v || w_xfer) begin
        // Skid valid implies ready_o = 0, so skid drain and accept never collide.
        r_main_v <= r_skid_v | w_accept;
        r_skid_v <= 1'b0;
        if (r_skid_v) r_main <= r_skid;
        else if (w_accept) r_main <= w_entry;
      end else if (w_accept) begin
        r_skid_v <= 1'b1;
        r_skid   <= w_entry;
      end
    end
  end
  assign valid_o        = r_main_v;
  assign result_o       = r_main.result;
  assign rd_o           = r_main.rd;
  assign rd_we_o        = r_main.rd_we;
  assign branch_taken_o = r_main.branch_taken;
  assign flags_o        = r_flags;
endmodule

// File: tb/tb_ex_out_stage.sv
// tb_ex_out_stage: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_ex_out_stage;
  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, ready_o, zero_flag_i, pos_flag_i, neg_flag_i, overflow_flag_i;
  logic        flag_we_i, branch_i, rd_we_i, flush_i, valid_o, ready_i, rd_we_o, branch_taken_o;
  logic [31:0] result_i, result_o;
  logic [3:0]  cond_i, flags_o;
  logic [4:0]  rd_i, rd_o;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        tk;
  } exp_t;
  exp_t       mq[$];
  logic [3:0] mflags;
  ex_out_stage #(.DATA_W(32), .RD_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .result_i(result_i),
    .zero_flag_i(zero_flag_i), .pos_flag_i(pos_flag_i), .neg_flag_i(neg_flag_i),
    .overflow_flag_i(overflow_flag_i), .flag_we_i(flag_we_i), .branch_i(branch_i),
    .cond_i(cond_i), .rd_i(rd_i), .rd_we_i(rd_we_i), .flush_i(flush_i), .valid_o(valid_o),
    .ready_i(ready_i), .result_o(result_o), .rd_o(rd_o), .rd_we_o(rd_we_o),
    .branch_taken_o(branch_taken_o), .flags_o(flags_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic cond_true(input logic [3:0] f, input logic [3:0] c);
    logic z, p, n, v;
    z = f[0]; p = f[1]; n = f[2]; v = f[3];
    case (c)
      4'd0: return 1'b1;
      4'd1: return z;
      4'd2: return !z;
      4'd3: return p;
      4'd4: return n;
      4'd5: return v;
      4'd6: return !v;
      4'd7: return p && !z;
      4'd8: return n || z;
      default: return 1'b0;
    endcase
  endfunction
  // Drives one cycle from a negedge, advances the model at the posedge, returns at the next negedge.
  task automatic step(input logic v, input logic [31:0] res, input logic [3:0] fl4, input logic fwe,
                      input logic br, input logic [3:0] cond, input logic rdy, input logic fls);
    logic acc, xfer;
    exp_t e;
    valid_i = v; result_i = res; flag_we_i = fwe; branch_i = br; cond_i = cond;
    ready_i = rdy; flush_i = fls; rd_i = 5'($urandom); rd_we_i = 1'($urandom);
    {overflow_flag_i, neg_flag_i, pos_flag_i, zero_flag_i} = fl4;
    acc  = v && (mq.size() < 2) && !fls;
    xfer = (mq.size() > 0) && rdy;
    e = '{res: res, rd: rd_i, we: rd_we_i, tk: br && cond_true(fwe ? fl4 : mflags, cond)};
    @(posedge clk_i);
    if (acc && fwe) mflags = fl4;
    if (xfer) void'(mq.pop_front());
    if (fls) mq.delete();
    else if (acc) mq.push_back(e);
    @(negedge clk_i);
    valid_i = 1'b0; flush_i = 1'b0;
  endtask
  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, rdy, 1'b0);
  endtask
  task automatic test_reset;
    rst_i = 1'b1;
    mq.delete(); mflags = 4'h0;
    @(negedge clk_i);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready_o); end
    checks++; if ({result_o, rd_o, rd_we_o, branch_taken_o} !== 39'h0) begin errors++; $display("FAIL reset_payload got=%h/%h/%b/%b want=0", result_o, rd_o, rd_we_o, branch_taken_o); end
    checks++; if (flags_o !== 4'h0) begin errors++; $display("FAIL reset_flags got=%b want=0000", flags_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask
  task automatic test_streaming;
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 32'(k), 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      checks++; if (valid_o !== 1'b1 || result_o !== 32'(k)) begin errors++; $display("FAIL stream_%0d got v=%b r=%h want v=1 r=%h", k, valid_o, result_o, k); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got=%b want=1", k, ready_o); end
    end
    idle(1'b1);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b want=0", valid_o); end
  endtask
  task automatic test_backpressure;
    step(1'b1, 32'hA, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b1, 32'hB, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    checks++; if (ready_o !== 1'b0 || result_o !== 32'hA) begin errors++; $display("FAIL bp_full got rdy=%b r=%h want rdy=0 r=a", ready_o, result_o); end
    step(1'b1, 32'hC, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    checks++; if (ready_o !== 1'b0 || result_o !== 32'hA || valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold got v=%b rdy=%b r=%h want v=1 rdy=0 r=a", valid_o, ready_o, result_o); end
    idle(1'b1);
    checks++; if (valid_o !== 1'b1 || result_o !== 32'hB || ready_o !== 1'b1) begin errors++; $display("FAIL bp_second got v=%b r=%h rdy=%b want v=1 r=b rdy=1", valid_o, result_o, ready_o); end
    idle(1'b1);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b want=0 (no dup of C)", valid_o); end
  endtask
  task automatic test_flags;
    step(1'b1, 32'h10, 4'b0001, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    checks++; if (flags_o !== 4'b0001) begin errors++; $display("FAIL flags_z got=%b want=0001", flags_o); end
    step(1'b1, 32'h11, 4'b1110, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
    checks++; if (branch_taken_o !== 1'b1) begin errors++; $display("FAIL br_eq got=%b want=1", branch_taken_o); end
    step(1'b1, 32'h12, 4'b1110, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
    checks++; if (branch_taken_o !== 1'b0 || flags_o !== 4'b0001) begin errors++; $display("FAIL br_ne got tk=%b f=%b want tk=0 f=0001", branch_taken_o, flags_o); end
    idle(1'b1);
  endtask
  task automatic test_cmp_branch;
    step(1'b1, 32'h20, 4'b0000, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b1, 32'h21, 4'b0100, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0);
    checks++; if (branch_taken_o !== 1'b1 || flags_o !== 4'b0100) begin errors++; $display("FAIL cmp_br got tk=%b f=%b want tk=1 f=0100", branch_taken_o, flags_o); end
    step(1'b1, 32'h22, 4'b0100, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    checks++; if (branch_taken_o !== 1'b0) begin errors++; $display("FAIL no_branch got=%b want=0", branch_taken_o); end
    step(1'b1, 32'h23, 4'b0000, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
    checks++; if (branch_taken_o !== 1'b0) begin errors++; $display("FAIL cond_never got=%b want=0", branch_taken_o); end
    idle(1'b1);
  endtask
  task automatic test_flush;
    step(1'b1, 32'h30, 4'b0010, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b1, 32'h31, 4'b0010, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL flush_fill got=%b want=0", ready_o); end
    step(1'b1, 32'h32, 4'b1111, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL flush_clear got v=%b rdy=%b want v=0 rdy=1", valid_o, ready_o); end
    checks++; if (flags_o !== 4'b0010) begin errors++; $display("FAIL flush_flags got=%b want=0010", flags_o); end
    step(1'b1, 32'h33, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    checks++; if (valid_o !== 1'b1 || result_o !== 32'h33) begin errors++; $display("FAIL flush_after got v=%b r=%h want v=1 r=33", valid_o, result_o); end
    idle(1'b1);
  endtask
  task automatic test_async_reset;
    step(1'b1, 32'h40, 4'b1010, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    step(1'b1, 32'h41, 4'b1010, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    #2 rst_i = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || flags_o !== 4'h0) begin errors++; $display("FAIL arst_ctl got v=%b rdy=%b f=%b want v=0 rdy=1 f=0000", valid_o, ready_o, flags_o); end
    checks++; if ({result_o, rd_o, rd_we_o, branch_taken_o} !== 39'h0) begin errors++; $display("FAIL arst_payload got=%h/%h/%b/%b want=0", result_o, rd_o, rd_we_o, branch_taken_o); end
    mq.delete(); mflags = 4'h0;
    @(negedge clk_i);
    rst_i = 1'b0;
    step(1'b1, 32'h42, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    checks++; if (valid_o !== 1'b1 || result_o !== 32'h42 || ready_o !== 1'b1) begin errors++; $display("FAIL arst_after got v=%b r=%h rdy=%b want v=1 r=42 rdy=1", valid_o, result_o, ready_o); end
    idle(1'b1);
  endtask
  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), $urandom, 4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0));
      checks++; if (valid_o !== (mq.size() > 0) || ready_o !== (mq.size() < 2)) begin errors++; $display("FAIL rnd_hs[%0d] got v=%b rdy=%b want v=%b rdy=%b", i, valid_o, ready_o, mq.size() > 0, mq.size() < 2); end
      checks++; if (flags_o !== mflags) begin errors++; $display("FAIL rnd_flags[%0d] got=%b want=%b", i, flags_o, mflags); end
      if (mq.size() > 0) begin
        checks++;
        if (result_o !== mq[0].res || rd_o !== mq[0].rd || rd_we_o !== mq[0].we || branch_taken_o !== mq[0].tk) begin
          errors++;
          $display("FAIL rnd_data[%0d] got %h/%h/%b/%b want %h/%h/%b/%b", i, result_o, rd_o, rd_we_o, branch_taken_o, mq[0].res, mq[0].rd, mq[0].we, mq[0].tk);
        end
      end
    end
  endtask
  initial begin
    {valid_i, zero_flag_i, pos_flag_i, neg_flag_i, overflow_flag_i, flag_we_i, branch_i, rd_we_i, flush_i} = '0;
    ready_i = 1'b1; result_i = '0; cond_i = '0; rd_i = '0;
    test_reset;
    test_streaming;
    test_backpressure;
    test_flags;
    test_cmp_branch;
    test_flush;
    test_async_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
